// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: opcodes, function codes, reset vector and ALU operation encoding
package mips_cpu_pkg;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC00000;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                         OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
                         FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09,
                         FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25,
                         FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;
endpackage

// File: rtl/mips_cpu_regfile.sv
// mips_cpu_regfile: 32x32 GPRs, two async reads, one sync write, $0 hardwired to zero
module mips_cpu_regfile
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] v0
);
  logic [31:0] regs [32];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0) regs[wa] <= wd;
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];
  assign v0  = regs[2];
endmodule

// File: rtl/mips_cpu_harvard.sv
// mips_cpu_harvard: single-cycle MIPS-I subset with branch delay slots and halt-on-PC-zero
module mips_cpu_harvard #(
  parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);
  import mips_cpu_pkg::*;
  logic [31:0] pc, npc, instr, rs_val, rt_val, imm, b, alu_res, ld_val, wd, pc4, target;
  logic [31:0] lane_mask, lane_data;
  logic [15:0] imm16, lhalf;
  logic [7:0]  lbyte;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, shamt, wa, sa;
  logic [1:0]  off;
  logic halted, reg_we, b_imm, imm_z, link, load, store, branch, jump, jump_reg, shift_var, taken, commit;
  alu_op_t alu_op;
  // Instruction bus delivers bytes in little-endian lane order; restore the MIPS word
  assign instr = {instr_readdata[7:0], instr_readdata[15:8], instr_readdata[23:16], instr_readdata[31:24]};
  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign shamt = instr[10:6];
  assign fn = instr[5:0];
  assign imm16 = instr[15:0];
  mips_cpu_regfile u_regfile (
    .clk(clk), .reset(reset), .we(commit & reg_we), .wa(wa), .wd(wd),
    .ra1(rs), .ra2(rt), .rd1(rs_val), .rd2(rt_val), .v0(register_v0)
  );
  always_comb begin
    alu_op = ALU_ADD; reg_we = 1'b0; wa = rt; b_imm = 1'b0; imm_z = 1'b0; link = 1'b0;
    load = 1'b0; store = 1'b0; branch = 1'b0; jump = 1'b0; jump_reg = 1'b0; shift_var = 1'b0;
    case (op)
      OP_SPECIAL: begin
        wa = rd;
        reg_we = 1'b1;
        case (fn)
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_SLLV: begin alu_op = ALU_SLL; shift_var = 1'b1; end
          FN_SRLV: begin alu_op = ALU_SRL; shift_var = 1'b1; end
          FN_SRAV: begin alu_op = ALU_SRA; shift_var = 1'b1; end
          FN_JR:   begin reg_we = 1'b0; jump_reg = 1'b1; end
          FN_JALR: begin jump_reg = 1'b1; link = 1'b1; end
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLTU: alu_op = ALU_SLTU;
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDIU: begin reg_we = 1'b1; b_imm = 1'b1; end
      OP_SLTI:  begin reg_we = 1'b1; b_imm = 1'b1; alu_op = ALU_SLT; end
      OP_SLTIU: begin reg_we = 1'b1; b_imm = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:  begin reg_we = 1'b1; b_imm = 1'b1; imm_z = 1'b1; alu_op = ALU_AND; end
      OP_ORI:   begin reg_we = 1'b1; b_imm = 1'b1; imm_z = 1'b1; alu_op = ALU_OR; end
      OP_XORI:  begin reg_we = 1'b1; b_imm = 1'b1; imm_z = 1'b1; alu_op = ALU_XOR; end
      OP_LUI:   begin reg_we = 1'b1; alu_op = ALU_LUI; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin reg_we = 1'b1; b_imm = 1'b1; load = 1'b1; end
      OP_SB, OP_SH, OP_SW: begin b_imm = 1'b1; store = 1'b1; end
      OP_BEQ, OP_BNE: branch = 1'b1;
      OP_J:   jump = 1'b1;
      OP_JAL: begin jump = 1'b1; link = 1'b1; reg_we = 1'b1; wa = 5'd31; end
      default: ;
    endcase
  end
  assign imm = imm_z ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
  assign b = b_imm ? imm : rt_val;
  assign sa = shift_var ? rs_val[4:0] : shamt;
  always_comb
    case (alu_op)
      ALU_ADD:  alu_res = rs_val + b;
      ALU_SUB:  alu_res = rs_val - b;
      ALU_AND:  alu_res = rs_val & b;
      ALU_OR:   alu_res = rs_val | b;
      ALU_XOR:  alu_res = rs_val ^ b;
      ALU_NOR:  alu_res = ~(rs_val | b);
      ALU_SLT:  alu_res = {31'h0, $signed(rs_val) < $signed(b)};
      ALU_SLTU: alu_res = {31'h0, rs_val < b};
      ALU_SLL:  alu_res = rt_val << sa;
      ALU_SRL:  alu_res = rt_val >> sa;
      ALU_SRA:  alu_res = $signed(rt_val) >>> sa;
      ALU_LUI:  alu_res = {imm16, 16'h0};
      default:  alu_res = '0;
    endcase
  assign off = alu_res[1:0];
  assign lbyte = data_readdata[{off, 3'b000} +: 8];
  assign lhalf = data_readdata[{off[1], 4'b0000} +: 16];
  assign ld_val = op == OP_LW  ? data_readdata :
                  op == OP_LB  ? {{24{lbyte[7]}}, lbyte} :
                  op == OP_LBU ? {24'h0, lbyte} :
                  op == OP_LH  ? {{16{lhalf[15]}}, lhalf} : {16'h0, lhalf};
  // Sub-word stores merge into the word read in the same cycle
  assign lane_mask = op == OP_SB ? 32'hFF << {off, 3'b000} : off[1] ? 32'hFFFF0000 : 32'h0000FFFF;
  assign lane_data = op == OP_SB ? {4{rt_val[7:0]}} : {2{rt_val[15:0]}};
  assign data_writedata = op == OP_SW ? rt_val : (data_readdata & ~lane_mask) | (lane_data & lane_mask);
  assign data_address = {alu_res[31:2], 2'b00};
  assign data_read = ~halted & (load | (store & op != OP_SW));
  assign data_write = ~halted & clk_enable & store;
  assign pc4 = pc + 32'd4;
  assign wd = link ? pc + 32'd8 : load ? ld_val : alu_res;
  assign taken = jump | jump_reg | (branch & ((rs_val == rt_val) ^ (op == OP_BNE)));
  assign target = jump_reg ? rs_val : jump ? {pc4[31:28], instr[25:0], 2'b00} :
                  pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign commit = clk_enable & ~halted;
  // npc holds the delay-slot successor, so a redirect lands one instruction late
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= RESET_VECTOR;
      npc <= RESET_VECTOR + 32'd4;
      halted <= 1'b0;
    end else if (commit) begin
      pc <= npc;
      npc <= taken ? target : npc + 32'd4;
      halted <= npc == 32'h0;
    end
  assign active = ~halted;
  assign instr_address = pc;
endmodule

// File: tb/tb_mips_cpu_harvard.sv
// tb_mips_cpu_harvard: directed programs against the Harvard CPU with bench-side memories
module tb_mips_cpu_harvard;
  localparam logic [31:0] BASE = 32'hBFC00000;
  logic clk = 0, reset = 1, clk_enable = 1;
  logic active, data_write, data_read;
  logic [31:0] register_v0, instr_address, instr_readdata, data_address, data_writedata, data_readdata;
  logic [31:0] imem [16];
  logic [31:0] dmem [16];
  logic [31:0] iword;
  int checks = 0, errors = 0;

  mips_cpu_harvard dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0), .clk_enable(clk_enable),
    .instr_address(instr_address), .instr_readdata(instr_readdata), .data_address(data_address),
    .data_write(data_write), .data_read(data_read), .data_writedata(data_writedata),
    .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;
  assign iword = instr_address[31:6] == BASE[31:6] ? imem[instr_address[5:2]] : 32'h0;
  assign instr_readdata = {iword[7:0], iword[15:8], iword[23:16], iword[31:24]};
  assign data_readdata = dmem[data_address[5:2]];
  always @(posedge clk) if (data_write) dmem[data_address[5:2]] <= data_writedata;

  task automatic clear_imem();
    for (int i = 0; i < 16; i++) imem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_imem();
    do_reset();
    checks++; if (instr_address !== BASE) begin errors++; $display("FAIL reset_pc got %h exp %h", instr_address, BASE); end
    checks++; if (register_v0 !== 32'h0) begin errors++; $display("FAIL reset_v0 got %h exp 0", register_v0); end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL reset_active got %b exp 1", active); end
  endtask

  task automatic test_byte_load();
    clear_imem();
    dmem[1] = 32'hDDCCBBAA;
    imem[0] = 32'h24210007; imem[1] = 32'h90220000; imem[2] = 32'h00000008; imem[3] = 32'h00000000;
    do_reset();
    step();
    checks++; if (data_address !== 32'h4 || data_read !== 1'b1) begin errors++; $display("FAIL lbu_bus got addr %h rd %b exp 4 1", data_address, data_read); end
    step();
    checks++; if (register_v0 !== 32'h000000DD) begin errors++; $display("FAIL lbu_v0 got %h exp 000000dd", register_v0); end
    step();
    step();
    checks++; if (instr_address !== 32'h0 || active !== 1'b0) begin errors++; $display("FAIL halt got pc %h active %b exp 0 0", instr_address, active); end
    checks++; if (data_read !== 1'b0 || data_write !== 1'b0) begin errors++; $display("FAIL halt_strobes got rd %b wr %b exp 0 0", data_read, data_write); end
    step();
    step();
    checks++; if (instr_address !== 32'h0 || active !== 1'b0 || register_v0 !== 32'hDD) begin errors++; $display("FAIL halt_hold got pc %h active %b v0 %h", instr_address, active, register_v0); end
  endtask

  task automatic test_signed_load();
    clear_imem();
    dmem[1] = 32'hDDCCBBAA;
    imem[0] = 32'h24010007; imem[1] = 32'h80220000;
    do_reset();
    step();
    step();
    checks++; if (register_v0 !== 32'hFFFFFFDD) begin errors++; $display("FAIL lb_v0 got %h exp ffffffdd", register_v0); end
  endtask

  task automatic test_store_byte();
    clear_imem();
    dmem[0] = 32'h11223344;
    imem[0] = 32'h240300AB; imem[1] = 32'hA0030001; imem[2] = 32'h8C020000;
    do_reset();
    step();
    checks++; if (data_writedata !== 32'h1122AB44) begin errors++; $display("FAIL sb_data got %h exp 1122ab44", data_writedata); end
    checks++; if (data_read !== 1'b1 || data_write !== 1'b1) begin errors++; $display("FAIL sb_strobes got rd %b wr %b exp 1 1", data_read, data_write); end
    step();
    step();
    checks++; if (register_v0 !== 32'h1122AB44) begin errors++; $display("FAIL sb_lw_v0 got %h exp 1122ab44", register_v0); end
  endtask

  task automatic test_delay_slot();
    clear_imem();
    imem[0] = 32'h10000002; imem[1] = 32'h24020005; imem[2] = 32'h24020009; imem[3] = 32'h24420001;
    do_reset();
    step();
    step();
    checks++; if (register_v0 !== 32'h5) begin errors++; $display("FAIL slot_v0 got %h exp 5", register_v0); end
    checks++; if (instr_address !== BASE + 32'hC) begin errors++; $display("FAIL slot_target got %h exp %h", instr_address, BASE + 32'hC); end
    step();
    checks++; if (register_v0 !== 32'h6) begin errors++; $display("FAIL slot_skip got %h exp 6", register_v0); end
  endtask

  task automatic test_freeze_reset();
    clear_imem();
    dmem[0] = 32'h00000055;
    imem[0] = 32'h24020003; imem[1] = 32'hAC020000;
    do_reset();
    step();
    clk_enable = 0;
    #1;
    checks++; if (data_write !== 1'b0) begin errors++; $display("FAIL freeze_wr got %b exp 0", data_write); end
    repeat (3) step();
    checks++; if (instr_address !== BASE + 32'h4 || register_v0 !== 32'h3) begin errors++; $display("FAIL freeze_state got pc %h v0 %h exp %h 3", instr_address, register_v0, BASE + 32'h4); end
    checks++; if (dmem[0] !== 32'h55) begin errors++; $display("FAIL freeze_mem got %h exp 55", dmem[0]); end
    clk_enable = 1;
    #1;
    checks++; if (data_write !== 1'b1 || data_writedata !== 32'h3) begin errors++; $display("FAIL unfreeze_wr got wr %b data %h exp 1 3", data_write, data_writedata); end
    clk_enable = 0;
    reset = 0;
    #1;
    checks++; if (instr_address !== BASE || register_v0 !== 32'h0) begin errors++; $display("FAIL async_reset got pc %h v0 %h exp %h 0", instr_address, register_v0, BASE); end
    @(negedge clk);
    reset = 1;
    clk_enable = 1;
  endtask

  task automatic test_reg_zero();
    clear_imem();
    imem[0] = 32'h24020004; imem[1] = 32'h24000009; imem[2] = 32'h00001021;
    do_reset();
    step();
    checks++; if (register_v0 !== 32'h4) begin errors++; $display("FAIL zero_pre got %h exp 4", register_v0); end
    step();
    step();
    checks++; if (register_v0 !== 32'h0) begin errors++; $display("FAIL zero_v0 got %h exp 0", register_v0); end
  endtask

  task automatic test_shift_jalr();
    clear_imem();
    imem[0] = 32'h3C028000; imem[1] = 32'h00021103;
    do_reset();
    step();
    step();
    checks++; if (register_v0 !== 32'hF8000000) begin errors++; $display("FAIL sra_v0 got %h exp f8000000", register_v0); end
    clear_imem();
    imem[0] = 32'h00001009;
    do_reset();
    step();
    checks++; if (register_v0 !== BASE + 32'h8) begin errors++; $display("FAIL jalr_link got %h exp %h", register_v0, BASE + 32'h8); end
    step();
    checks++; if (active !== 1'b0 || instr_address !== 32'h0) begin errors++; $display("FAIL jalr_halt got active %b pc %h exp 0 0", active, instr_address); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
    test_reset();
    test_byte_load();
    test_signed_load();
    test_store_byte();
    test_delay_slot();
    test_freeze_reset();
    test_reg_zero();
    test_shift_jalr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
